// File: rtl/child_fanin_collector.sv
// rtl/child_fanin_collector.sv - round-robin merge of child result beats into one tagged upstream stream
module child_fanin_collector #(
    parameter int NUM_CHILD = 5,
    parameter int DATA_W    = 16,
    parameter int IDX_W     = $clog2(NUM_CHILD)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CHILD-1:0]        in_valid,
    input  logic [NUM_CHILD*DATA_W-1:0] in_data,
    output logic [NUM_CHILD-1:0]        in_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic [IDX_W-1:0]            out_idx,
    input  logic                        out_ready,
    output logic                        round_done
);

    localparam int ENTRY_W = IDX_W + DATA_W;

    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [NUM_CHILD-1:0] seen_q, seen_d;
    logic [1:0]           count_q, count_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic [ENTRY_W-1:0]   mem_q [2];
    logic [ENTRY_W-1:0]   mem_d [2];
    logic                 round_done_q, round_done_d;

    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [NUM_CHILD-1:0] win_onehot;
    logic [DATA_W-1:0]    win_data;
    logic                 can_push;
    logic                 push;
    logic                 pop;
    logic [NUM_CHILD-1:0] seen_next;

    // Pick the first requesting child at or after the rotating pointer
    always_comb begin
        int cand;
        cand       = 0;
        win_found  = 1'b0;
        win_idx    = '0;
        for (int k = 0; k < NUM_CHILD; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_CHILD) begin
                cand = cand - NUM_CHILD;
            end
            if (!win_found && in_valid[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Grant only the winner, only when the buffer has room, and never while in reset
    always_comb begin
        win_onehot          = '0;
        win_onehot[win_idx] = 1'b1;
        win_data            = in_data[int'(win_idx)*DATA_W +: DATA_W];
        can_push            = (count_q != 2'd2);
        in_ready            = (win_found && can_push && rst_n) ? win_onehot : '0;
        push                = |(in_valid & in_ready);
        pop                 = (count_q != 2'd0) && out_ready;
    end

    // Next-state for the arbiter pointer, round mask and the 2-entry buffer
    always_comb begin
        ptr_d        = ptr_q;
        seen_d       = seen_q;
        seen_next    = seen_q | win_onehot;
        round_done_d = 1'b0;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        mem_d        = mem_q;

        if (push) begin
            ptr_d = (win_idx == IDX_W'(NUM_CHILD - 1)) ? '0 : win_idx + 1'b1;
            mem_d[wr_ptr_q] = {win_idx, win_data};
            wr_ptr_d        = ~wr_ptr_q;
            // The completing accept clears the mask so the next round starts empty
            if (&seen_next) begin
                round_done_d = 1'b1;
                seen_d       = '0;
            end else begin
                seen_d = seen_next;
            end
        end

        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards buffered beats immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= '0;
            seen_q       <= '0;
            count_q      <= 2'd0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            mem_q[0]     <= '0;
            mem_q[1]     <= '0;
            round_done_q <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            seen_q       <= seen_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            mem_q[0]     <= mem_d[0];
            mem_q[1]     <= mem_d[1];
            round_done_q <= round_done_d;
        end
    end

    // Upstream view is the buffer head
    always_comb begin
        out_valid  = (count_q != 2'd0);
        out_data   = mem_q[rd_ptr_q][DATA_W-1:0];
        out_idx    = mem_q[rd_ptr_q][ENTRY_W-1:DATA_W];
        round_done = round_done_q;
    end

endmodule

// File: doc/child_fanin_collector.md
# child_fanin_collector

Gathers result beats from the five child instances under a root node and merges them into one upstream stream toward the parent, the return path of the root-to-child fan-out. Round-robin arbitration across child request ports, a 2-entry output buffer, and a source index tag on every beat. A per-round completion pulse tells the parent when every child has delivered at least once.

## Interface
Parameters:
- NUM_CHILD, 5, number of child request ports (2..16)
- DATA_W, 16, payload width per beat
- IDX_W, $clog2(NUM_CHILD), child index tag width (min 1)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset; deassertion synchronous to clk externally
- in_valid  input  NUM_CHILD  per-child beat valid
- in_data  input  NUM_CHILD*DATA_W  child i payload at [i*DATA_W +: DATA_W]
- in_ready  output  NUM_CHILD  per-child accept, at most one bit set
- out_valid  output  1  upstream beat valid
- out_data  output  DATA_W  upstream payload
- out_idx  output  IDX_W  index of child that produced out_data
- out_ready  input  1  upstream accept
- round_done  output  1  one-cycle pulse: every child delivered since last pulse

## Operation
- Arbiter: rotating priority pointer `ptr` (reset 0). Winner = first i in ptr, ptr+1, …, NUM_CHILD-1, 0, … with in_valid[i]=1.
- in_ready[winner] = 1 iff buffer count < 2; all other in_ready bits 0. in_ready depends only on in_valid and registered state, never on out_ready.
- Accept = in_valid[i] & in_ready[i]. On accept: push {i, data} into buffer; ptr <= (i+1) mod NUM_CHILD. No accept: ptr holds.
- Buffer: 2-entry FIFO, order preserved. out_valid = count != 0; out_data/out_idx = head entry. Pop when out_valid & out_ready.
- Full (count=2): no push this cycle even if a pop occurs.
- Simultaneous push and pop with count=1: count stays 1, new entry becomes head next cycle.
- Round tracking: `seen` mask (NUM_CHILD bits, reset 0). On accept from i, seen[i] <= 1. If that accept makes seen all ones, round_done = 1 next cycle and seen clears to 0. Repeat beats from the same child within a round do not trigger a pulse.
- Children must hold in_valid/in_data stable until accepted. Dropping in_valid early is tolerated: the beat is simply not taken.

## Timing
- Reset values: in_ready all 0 while rst_n low, out_valid 0, out_data 0, out_idx 0, round_done 0. ptr, seen and count are all 0.
- Reset asserted mid-operation: buffer contents are discarded immediately (asynchronous), and outputs take reset values in the same cycle.
- Latency: accepted beat appears on out_valid the next cycle when the buffer was empty. Throughput is 1 beat/cycle with out_ready held high.
- round_done rises the cycle after the completing accept and lasts exactly 1 cycle.
- Upstream stall: with out_ready low, at most 2 beats are accepted, then all in_ready go 0 until a pop lowers count.

## Test plan
- Reset: hold rst_n=0 with all in_valid=1 -> in_ready=0, out_valid=0, round_done=0. Release, out_ready=1 -> first beat from child 0 (out_idx=0) one cycle later.
- Fairness: all 5 in_valid=1, data=0x1000+i, out_ready=1 -> out_idx sequence 0,1,2,3,4,0 on consecutive cycles. round_done pulses once, the cycle after child 4's accept.
- Sparse requests: only children 3 and 1 valid, ptr=0 -> order 1,3,1,3. round_done never pulses.
- Backpressure: out_ready=0, all valid -> exactly 2 accepts (idx 0,1), then in_ready=0. Raise out_ready -> 0,1,2,… with no loss or duplication.
- Push/pop overlap: count=1, out_ready=1, new request from child 2 -> count stays 1 and out_idx=2 on the next cycle.
- Mid-stream reset: assert rst_n=0 with count=2 -> out_valid drops immediately. After release, seen has cleared and 5 further accepts are needed for round_done.
